// File: rtl/mem_cfg_pkg.sv
// -----------------------------------------------------------------------------
// mem_cfg_pkg
// Shared definitions for the switch configuration-bus arbiter:
//   NUM_REQ / ADDR_W / DATA_W  - requester count and per-lane bus widths
//   TIMEOUT_DEFAULT            - default cycle budget waiting for mem_ack
//   state_t                    - arbiter FSM states (IDLE, BUS, RESP)
//   onehot_to_idx()            - one-hot grant vector to requester index
// -----------------------------------------------------------------------------
package mem_cfg_pkg;

  localparam int NUM_REQ         = 4;
  localparam int ADDR_W          = 8;
  localparam int DATA_W          = 8;
  localparam int TIMEOUT_DEFAULT = 16;
  localparam int GRANT_W         = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [GRANT_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [GRANT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = GRANT_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The search begins one past the previous
// winner and wraps, so every requester is served within NUM_REQ grants.
// Ports:
//   req_i        - request vector
//   last_grant_i - index of the most recent winner
//   grant_o      - one-hot winner (all zero when no request)
// -----------------------------------------------------------------------------
module rr_arbiter
  import mem_cfg_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GRANT_W-1:0] last_grant_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic               found;
  logic [GRANT_W-1:0] idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    // Index arithmetic wraps naturally at GRANT_W bits (NUM_REQ is a power of 2).
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = last_grant_i + GRANT_W'(k);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// mem_cfg_arbiter
// Arbitrates four requesters onto a single switch configuration bus.
//
// Handshake: a requester raises req[i] with its op/addr/data lanes and holds it
// until done[i] pulses for one cycle; rsp_rd_data/rsp_err are valid only in that
// cycle. On the bus side mem_sel_en stays high with constant addr/data/op until
// any mem_ack bit is sampled high or TIMEOUT cycles elapse; an ack arriving while
// mem_sel_en is low is ignored.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   req, req_wr_rd_s         - per-requester request and op (1=write)
//   req_addr, req_wr_data    - per-requester 8-bit lanes, lane i at [8i+7:8i]
//   done, rsp_rd_data, rsp_err - completion pulse and response
//   busy                     - FSM not in IDLE
//   mem_sel_en, mem_wr_rd_s, mem_addr, mem_wr_data - registered bus drive
//   mem_rd_data, mem_ack     - bus return
//   dbg_state                - current FSM state for observation
// -----------------------------------------------------------------------------
module mem_cfg_arbiter
  import mem_cfg_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_wr_rd_s,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rsp_rd_data,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      mem_sel_en,
  output logic                      mem_wr_rd_s,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wr_data,
  input  logic [DATA_W-1:0]         mem_rd_data,
  input  logic [NUM_REQ-1:0]        mem_ack,
  output logic [1:0]                dbg_state
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t              state_q;
  logic [GRANT_W-1:0]  last_grant_q;
  logic [GRANT_W-1:0]  winner_q;
  logic [7:0]          cnt_q;
  logic                sel_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [NUM_REQ-1:0]  done_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic [NUM_REQ-1:0]  grant;
  logic [GRANT_W-1:0]  grant_idx;

  rr_arbiter u_rr (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  assign grant_idx = onehot_to_idx(grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_W'(NUM_REQ - 1);  // first search starts at 0
      winner_q     <= '0;
      cnt_q        <= '0;
      sel_q        <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      done_q       <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            winner_q     <= grant_idx;
            last_grant_q <= grant_idx;
            wr_q         <= req_wr_rd_s[grant_idx];
            addr_q       <= req_addr[grant_idx*ADDR_W +: ADDR_W];
            wdata_q      <= req_wr_data[grant_idx*DATA_W +: DATA_W];
            sel_q        <= 1'b1;
            cnt_q        <= 8'd1;
            state_q      <= BUS;
          end
        end
        BUS: begin
          // Ack is tested first so an ack on the final allowed cycle wins.
          if (|mem_ack) begin
            sel_q   <= 1'b0;
            done_q  <= ONE << winner_q;
            err_q   <= 1'b0;
            rdata_q <= wr_q ? '0 : mem_rd_data;
            state_q <= RESP;
          end else if (cnt_q == TIMEOUT_CNT) begin
            sel_q   <= 1'b0;
            done_q  <= ONE << winner_q;
            err_q   <= 1'b1;
            rdata_q <= '0;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP: begin
          // Single response cycle; requests are not sampled here.
          done_q  <= '0;
          err_q   <= 1'b0;
          rdata_q <= '0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done        = done_q;
  assign rsp_rd_data = rdata_q;
  assign rsp_err     = err_q;
  assign busy        = (state_q != IDLE);
  assign mem_sel_en  = sel_q;
  assign mem_wr_rd_s = wr_q;
  assign mem_addr    = addr_q;
  assign mem_wr_data = wdata_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_cfg_arbiter.sv
module tb_mem_cfg_arbiter;
  import mem_cfg_pkg::*;

  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, req_wr_rd_s, mem_ack, done;
  logic [31:0] req_addr, req_wr_data;
  logic [7:0]  rsp_rd_data, mem_addr, mem_wr_data, mem_rd_data;
  logic        rsp_err, busy, mem_sel_en, mem_wr_rd_s;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  mem_cfg_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr_rd_s(req_wr_rd_s),
    .req_addr(req_addr), .req_wr_data(req_wr_data), .done(done),
    .rsp_rd_data(rsp_rd_data), .rsp_err(rsp_err), .busy(busy),
    .mem_sel_en(mem_sel_en), .mem_wr_rd_s(mem_wr_rd_s), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_ack(mem_ack),
    .dbg_state(dbg_state)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int model_last = 3;
  int last_done_cyc = -100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference rule: scan indices last+1, last+2, ... modulo 4.
  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  typedef struct {
    bit         do_rst;
    logic [3:0] req;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] rd;
    int         ack_at;   // BUS cycle (1-based) carrying ack; 0 or >TO = none
    logic [3:0] ack;
    bit         drop;     // requester releases req in BUS cycle 2
    bit         stray;    // ack driven while idle at the grant edge
    int         exp_win;
  } vec_t;

  vec_t tbl[11];

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; mem_ack = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_last = 3;
    last_done_cyc = -100;
  endtask

  // Called at a negedge with the DUT idle; returns at the idle negedge after RESP.
  task automatic run_txn(input vec_t v, input int exp_win);
    bit         ok_ack, exited, stable;
    int         exp_sel, sel_cycles;
    logic [7:0] exp_rd;
    logic [3:0] exp_done;

    chk("idle_done", 32'(done), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);

    for (int i = 0; i < 4; i++) begin
      req_addr[8*i +: 8]    = (i == exp_win) ? v.addr : ~v.addr;
      req_wr_data[8*i +: 8] = (i == exp_win) ? v.data : ~v.data;
    end
    req_wr_rd_s = {4{v.wr}};
    req         = v.req;
    mem_rd_data = v.rd;
    mem_ack     = v.stray ? 4'b1111 : 4'b0000;

    ok_ack   = (v.ack_at >= 1 && v.ack_at <= TO);
    exp_sel  = ok_ack ? v.ack_at : TO;
    exp_rd   = (ok_ack && !v.wr) ? v.rd : 8'h00;
    exp_done = 4'b0001 << exp_win;

    @(negedge clk);
    chk("grant_sel_en", 32'(mem_sel_en), 32'h1);
    chk("grant_addr", 32'(mem_addr), 32'(v.addr));
    chk("grant_wdata", 32'(mem_wr_data), 32'(v.data));
    chk("grant_wr", 32'(mem_wr_rd_s), 32'(v.wr));
    chk("grant_busy", 32'(busy), 32'h1);

    sel_cycles = 0; exited = 0; stable = 1;
    for (int c = 1; c <= TO + 3 && !exited; c++) begin
      if (c > 1) @(negedge clk);
      if (mem_sel_en) begin
        sel_cycles++;
        if (mem_addr !== v.addr || mem_wr_data !== v.data ||
            mem_wr_rd_s !== v.wr || done !== 4'b0) stable = 0;
        mem_ack = (c == v.ack_at) ? v.ack : 4'b0000;
        if (v.drop && c == 2) req = 4'b0000;
      end else begin
        exited  = 1;
        mem_ack = 4'b0000;
        chk("resp_done", 32'(done), 32'(exp_done));
        chk("resp_err", 32'(rsp_err), 32'(!ok_ack));
        chk("resp_rd_data", 32'(rsp_rd_data), 32'(exp_rd));
        chk("resp_state", 32'(dbg_state), 32'(RESP));
        chk("sel_cycles", 32'(sel_cycles), 32'(exp_sel));
        chk("bus_stable", 32'(stable), 32'h1);
        if (last_done_cyc >= 0) chk("done_gap_ge3", 32'(cyc - last_done_cyc >= 3), 32'h1);
        last_done_cyc = cyc;
      end
    end
    chk("bus_exit_in_bound", 32'(exited), 32'h1);
    model_last = exp_win;
    @(negedge clk);
  endtask

  // ---------------- test ----------------
  initial begin
    rst = 1'b1; req = '0; req_wr_rd_s = '0; req_addr = '0; req_wr_data = '0;
    mem_rd_data = '0; mem_ack = '0;
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_sel_en", 32'(mem_sel_en), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;

    tbl[0]  = '{1, 4'b0001, 1, 8'h10, 8'hA5, 8'h00,  1, 4'b0001, 0, 0, 0};
    tbl[1]  = '{0, 4'b0100, 0, 8'h22, 8'h00, 8'h3C,  1, 4'b0100, 0, 0, 2};
    tbl[2]  = '{1, 4'b1111, 1, 8'h30, 8'h01, 8'h00,  1, 4'b0001, 0, 0, 0};
    tbl[3]  = '{0, 4'b1111, 0, 8'h31, 8'h02, 8'h11,  1, 4'b0010, 0, 0, 1};
    tbl[4]  = '{0, 4'b1111, 1, 8'h32, 8'h03, 8'h00,  1, 4'b0100, 0, 0, 2};
    tbl[5]  = '{0, 4'b1111, 0, 8'h33, 8'h04, 8'h22,  1, 4'b1000, 0, 0, 3};
    tbl[6]  = '{0, 4'b1111, 1, 8'h34, 8'h05, 8'h00,  1, 4'b0001, 0, 0, 0};
    tbl[7]  = '{0, 4'b0010, 0, 8'h40, 8'h00, 8'h55,  0, 4'b0000, 0, 0, 1};
    tbl[8]  = '{0, 4'b1000, 0, 8'h41, 8'h00, 8'h77, 16, 4'b0010, 0, 0, 3};
    tbl[9]  = '{0, 4'b0001, 1, 8'h42, 8'h99, 8'h00,  3, 4'b0001, 1, 1, 0};
    tbl[10] = '{0, 4'b0011, 0, 8'h43, 8'h00, 8'hC3,  2, 4'b1111, 0, 0, 1};

    foreach (tbl[i]) begin
      if (tbl[i].do_rst) do_reset();
      run_txn(tbl[i], tbl[i].exp_win);
    end

    // Stray ack while idle with no request: nothing may move.
    mem_ack = 4'b1111;
    repeat (3) @(negedge clk);
    chk("stray_busy", 32'(busy), 32'h0);
    chk("stray_sel_en", 32'(mem_sel_en), 32'h0);
    chk("stray_done", 32'(done), 32'h0);
    mem_ack = 4'b0000;

    // Reset in BUS cycle 3: everything clears, no done.
    req = 4'b0001; req_wr_rd_s = 4'b1111; req_addr = 32'h5A5A5A5A; req_wr_data = 32'hC3C3C3C3;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_sel_en", 32'(mem_sel_en), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_addr", 32'(mem_addr), 32'h0);
    chk("midrst_wdata", 32'(mem_wr_data), 32'h0);
    chk("midrst_wr", 32'(mem_wr_rd_s), 32'h0);
    chk("midrst_err_rd", 32'({rsp_err, rsp_rd_data}), 32'h0);
    rst = 1'b0;
    model_last = 3;
    last_done_cyc = -100;
    // Grant on the first edge after reset release; req0 present so it wins.
    run_txn('{0, 4'b0011, 1, 8'h61, 8'h62, 8'h00, 1, 4'b0001, 0, 0, 0}, pick(4'b0011, model_last));
    do_reset();
    run_txn('{0, 4'b0010, 0, 8'h63, 8'h00, 8'h64, 2, 4'b0010, 0, 0, 1}, pick(4'b0010, model_last));

    // Randomized traffic against the reference rules.
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      if ($urandom_range(0, 9) == 0) do_reset();
      v.do_rst = 0;
      v.req    = 4'($urandom_range(1, 15));
      v.wr     = 1'($urandom_range(0, 1));
      v.addr   = 8'($urandom);
      v.data   = 8'($urandom);
      v.rd     = 8'($urandom);
      v.ack_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO + 2))
                                             : int'($urandom_range(1, 4));
      v.ack    = 4'($urandom_range(1, 15));
      v.drop   = ($urandom_range(0, 3) == 0);
      v.stray  = ($urandom_range(0, 3) == 0);
      v.exp_win = pick(v.req, model_last);
      run_txn(v, v.exp_win);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_cfg_arbiter.md
MEM_CFG_ARBITER -- requirements
Module: mem_cfg_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the max cycles mem_sel_en stays high awaiting ack (legal 2..255).
REQ-002 Port clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-003 Port rst  in  1  reset, synchronous, active-high.
REQ-004 Port req  in  4  per-requester access request, held until done.
REQ-005 Port req_wr_rd_s  in  4  per-requester op select, 1=write, 0=read.
REQ-006 Port req_addr  in  32  requester i address in bits [8i+7:8i].
REQ-007 Port req_wr_data  in  32  requester i write data in bits [8i+7:8i].
REQ-008 Port done  out  4  one-cycle completion pulse to requester i.
REQ-009 Port rsp_rd_data  out  8  read data, valid only while done is nonzero.
REQ-010 Port rsp_err  out  1  timeout flag, valid only while done is nonzero.
REQ-011 Port busy  out  1  high whenever state is not IDLE.
REQ-012 Ports mem_sel_en, mem_wr_rd_s (out 1), mem_addr, mem_wr_data (out 8): switch config bus drive, all registered.
REQ-013 Ports mem_rd_data (in 8), mem_ack (in 4): bus return; any nonzero mem_ack means access complete.

Function
REQ-014 FSM SHALL have states IDLE, BUS, RESP.
REQ-015 IDLE: on any req bit sampled high at edge T, SHALL pick the winner round-robin, latch its addr/data/op, enter BUS with mem_sel_en=1 from T+1.
REQ-016 Round-robin: search SHALL start at index (last_grant+1) mod 4; after reset search starts at 0.
REQ-017 BUS: mem_sel_en, mem_addr, mem_wr_data, mem_wr_rd_s SHALL remain constant until exit.
REQ-018 BUS: mem_ack nonzero sampled at edge A SHALL deassert mem_sel_en from A+1, pulse done[winner] at A+1, rsp_err=0, rsp_rd_data=mem_rd_data sampled at A for reads, 0 for writes; state RESP.
REQ-019 BUS: cycle counter SHALL start at 1 on entry; if it reaches TIMEOUT with no ack, SHALL exit as REQ-018 but rsp_err=1, rsp_rd_data=0.
REQ-020 Ack and timeout in the same cycle: ack SHALL win (rsp_err=0).
REQ-021 RESP lasts exactly one cycle, SHALL ignore req, then IDLE; minimum req-to-done latency is 2 cycles, back-to-back grant spacing 3 cycles.
REQ-022 mem_ack while mem_sel_en low SHALL be ignored.
REQ-023 req dropped by the winner mid-access SHALL NOT abort; access completes and done still pulses.
REQ-024 At most one done bit SHALL be high in any cycle; done outside RESP SHALL be 0.

Reset
REQ-025 rst high at an edge SHALL force IDLE, last_grant=3, counter=0, all outputs 0, regardless of state (mid-access included, no done issued).
REQ-026 First grant SHALL be possible on the edge after rst deasserts.

Structure
REQ-027 Shared package mem_cfg_pkg SHALL hold the state enum, NUM_REQ=4, address/data widths, and TIMEOUT default.
REQ-028 Round-robin selection SHALL live in sub-module rr_arbiter (req, last_grant in; one-hot grant out, combinational).

Verification
REQ-029 Single write: req=0001, addr 0x10, data 0xA5, ack=0001 one cycle after sel_en -> bus shows 0x10/0xA5/wr=1, done=0001 two cycles after req, rsp_err=0.
REQ-030 Read: req=0100, addr 0x22, mem_rd_data=0x3C with ack -> done=0100, rsp_rd_data=0x3C.
REQ-031 Fairness: req=1111 held continuously -> grant order 0,1,2,3,0, each done 3+ cycles apart.
REQ-032 Timeout: TIMEOUT=16, no ack -> mem_sel_en high exactly 16 cycles, done pulse with rsp_err=1, rsp_rd_data=0; ack arriving on cycle 16 -> rsp_err=0.
REQ-033 Reset mid-BUS: rst asserted during cycle 3 of access -> next cycle all outputs 0, no done; req=0010 afterwards granted before req0 only if req0 absent.
REQ-034 Stray ack in IDLE and req drop mid-access -> no state change; dropped access still completes with done.
